// File: rtl/ecg_sim_pkg.sv
// Shared definitions for the ECG simulator scheduler: mode codes, FSM encoding and
// packet field widths.
package ecg_sim_pkg;

   localparam int unsigned FIELD_W = 12;

   localparam logic [2:0] MODE_NORMAL  = 3'd1;
   localparam logic [2:0] MODE_TACHY   = 3'd2;
   localparam logic [2:0] MODE_LOW_HRV = 3'd3;

   typedef enum logic [1:0] {
      StSettle = 2'd0,
      StSample = 2'd1,
      StSend   = 2'd2,
      StWait   = 2'd3
   } state_e;

   // Auto-cycle order: normal -> tachycardia -> low-HRV -> normal.
   function automatic logic [2:0] next_mode(input logic [2:0] mode);
      case (mode)
         MODE_NORMAL: return MODE_TACHY;
         MODE_TACHY:  return MODE_LOW_HRV;
         default:     return MODE_NORMAL;
      endcase
   endfunction

   function automatic logic mode_legal(input logic [2:0] mode);
      return (mode == MODE_NORMAL) || (mode == MODE_TACHY) || (mode == MODE_LOW_HRV);
   endfunction

endpackage

// File: rtl/ecg_mode_sequencer.sv
// Tracks pending mode-change requests (manual or auto-advance) and the per-mode packet
// count; the scheduler FSM applies the pending mode when its sample period ends.
module ecg_mode_sequencer
   import ecg_sim_pkg::*;
#(
   parameter logic [7:0] PKTS_PER_MODE = 8'd3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       auto_en,
   input  logic [2:0] manual_sel,
   input  logic       manual_load,
   input  logic [2:0] cur_sel,
   input  logic       pkt_done,
   input  logic       mode_taken,
   output logic       apply_mode,
   output logic [2:0] new_sel
);

   logic        pending_q, pending_d;
   logic        manual_q, manual_d;
   logic [2:0]  sel_q, sel_d;
   logic [15:0] dwell_q, dwell_d;
   logic        auto_fire;

   // Auto request is level-based on the dwell count; an existing request blocks it.
   assign auto_fire = auto_en && !pending_q && !mode_taken &&
                      (dwell_q == {8'd0, PKTS_PER_MODE});

   always_comb begin
      pending_d = pending_q;
      manual_d  = manual_q;
      sel_d     = sel_q;
      dwell_d   = dwell_q;
      if (pkt_done) dwell_d = dwell_q + 16'd1;
      if (mode_taken) begin
         pending_d = 1'b0;
         manual_d  = 1'b0;
         dwell_d   = '0;
      end
      if (!auto_en && pending_q && !manual_q) pending_d = 1'b0;
      if (auto_fire) begin
         pending_d = 1'b1;
         manual_d  = 1'b0;
         sel_d     = next_mode(cur_sel);
      end
      if (manual_load && mode_legal(manual_sel)) begin
         pending_d = 1'b1;
         manual_d  = 1'b1;
         sel_d     = manual_sel;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= 1'b0;
         manual_q  <= 1'b0;
         sel_q     <= MODE_NORMAL;
         dwell_q   <= '0;
      end else begin
         pending_q <= pending_d;
         manual_q  <= manual_d;
         sel_q     <= sel_d;
         dwell_q   <= dwell_d;
      end
   end

   assign apply_mode = pending_q;
   assign new_sel    = sel_q;

endmodule

// File: rtl/ecg_sim_scheduler.sv
// Sequences the ECG parameter simulator: selects its mode, waits for it to settle and
// delivers periodic tagged snapshots over a valid/ready handshake.
module ecg_sim_scheduler
   import ecg_sim_pkg::*;
#(
   parameter logic [15:0] SETTLE_CYCLES = 16'd52,
   parameter logic [15:0] SAMPLE_PERIOD = 16'd100,
   parameter logic [7:0]  PKTS_PER_MODE = 8'd3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               auto_en,
   input  logic [2:0]         manual_sel,
   input  logic               manual_load,
   input  logic [FIELD_W-1:0] heart_rate,
   input  logic [FIELD_W-1:0] rr_interval,
   input  logic [FIELD_W-1:0] hrv_value,
   output logic [2:0]         data_sel,
   output logic               pkt_valid,
   input  logic               pkt_ready,
   output logic [2:0]         pkt_mode,
   output logic [FIELD_W-1:0] pkt_hr,
   output logic [FIELD_W-1:0] pkt_rr,
   output logic [FIELD_W-1:0] pkt_hrv,
   output logic [15:0]        pkt_count
);

   state_e      state_q;
   logic [15:0] cnt_q;
   logic        handshake;
   logic        period_done;
   logic        mode_taken;
   logic        apply_mode;
   logic [2:0]  new_sel;

   assign handshake   = pkt_valid && pkt_ready;
   assign period_done = (state_q == StWait) && (cnt_q == SAMPLE_PERIOD - 16'd1);
   assign mode_taken  = period_done && apply_mode;

   ecg_mode_sequencer #(
      .PKTS_PER_MODE(PKTS_PER_MODE)
   ) u_seq (
      .clk        (clk),
      .rst_n      (rst_n),
      .auto_en    (auto_en),
      .manual_sel (manual_sel),
      .manual_load(manual_load),
      .cur_sel    (data_sel),
      .pkt_done   (handshake),
      .mode_taken (mode_taken),
      .apply_mode (apply_mode),
      .new_sel    (new_sel)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StSettle;
         cnt_q     <= '0;
         data_sel  <= MODE_NORMAL;
         pkt_valid <= 1'b0;
         pkt_mode  <= '0;
         pkt_hr    <= '0;
         pkt_rr    <= '0;
         pkt_hrv   <= '0;
         pkt_count <= '0;
      end else begin
         case (state_q)
            StSettle: begin
               if (cnt_q == SETTLE_CYCLES - 16'd1) begin
                  cnt_q   <= '0;
                  state_q <= StSample;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            StSample: begin
               pkt_hr    <= heart_rate;
               pkt_rr    <= rr_interval;
               pkt_hrv   <= hrv_value;
               pkt_mode  <= data_sel;
               pkt_valid <= 1'b1;
               state_q   <= StSend;
            end
            StSend: begin
               if (handshake) begin
                  pkt_valid <= 1'b0;
                  pkt_count <= pkt_count + 16'd1;
                  state_q   <= StWait;
               end
            end
            StWait: begin
               if (period_done) begin
                  cnt_q <= '0;
                  // Mode only ever changes here, so no packet sees a mid-flight switch.
                  if (apply_mode) begin
                     data_sel <= new_sel;
                     state_q  <= StSettle;
                  end else begin
                     state_q <= StSample;
                  end
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            default: state_q <= StSettle;
         endcase
      end
   end

endmodule

// File: doc/ecg_sim_scheduler.md
Name: ecg_sim_scheduler

Overview:
Controller that sequences ecg_parameter_simulator.
- Drives its data_sel mode input, either auto-cycling through normal → tachycardia → low-HRV or taking a manual override.
- After each mode change, waits for the simulator to settle, then periodically snapshots heart_rate/rr_interval/hrv_value into a tagged packet.
- Delivers each packet over a valid/ready handshake to the downstream display/UART formatter.

Parameters:
SETTLE_CYCLES, 16'd52, cycles held after a data_sel change before first sample; must exceed the simulator's longest update period (51).
SAMPLE_PERIOD, 16'd100, cycles from a completed handshake to the next sample.
PKTS_PER_MODE, 8'd3, packets sent per mode before auto-advance.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
auto_en  in  1  1 = auto-cycle modes; 0 = hold current mode
manual_sel  in  3  requested mode; legal values 1..3
manual_load  in  1  single-cycle pulse to request manual_sel
heart_rate  in  12  from simulator, bpm
rr_interval  in  12  from simulator, ms
hrv_value  in  12  from simulator, ms
data_sel  out  3  mode to simulator
pkt_valid  out  1  packet available
pkt_ready  in  1  downstream accept
pkt_mode  out  3  data_sel at sample time
pkt_hr  out  12  sampled heart_rate
pkt_rr  out  12  sampled rr_interval
pkt_hrv  out  12  sampled hrv_value
pkt_count  out  16  completed handshakes, wraps 16'hFFFF → 0

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset values:
  - data_sel=3'd1, pkt_valid=0, pkt_mode=0, pkt_hr/pkt_rr/pkt_hrv=0, pkt_count=0.
  - Internal: state=SETTLE, cycle counter=0, dwell (packet) counter=0, pending flag=0.
- FSM states: SETTLE, SAMPLE, SEND, WAIT.
- SETTLE:
  - Counter increments each cycle.
  - When counter==SETTLE_CYCLES-1: clear counter, go to SAMPLE. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (1 cycle):
  - Register the simulator inputs into pkt_hr/rr/hrv and data_sel into pkt_mode.
  - Set pkt_valid=1 and go to SEND.
  - pkt_valid is first visible on the cycle after SAMPLE, i.e. SETTLE_CYCLES+1 edges after reset release.
- SEND:
  - pkt_valid and all pkt_* fields are held stable until a cycle with pkt_valid && pkt_ready.
  - On that edge: pkt_valid←0, pkt_count++, dwell counter++, go to WAIT.
  - pkt_ready while pkt_valid=0 is ignored.
  - No timeout: backpressure is unbounded.
- WAIT:
  - Counter increments each cycle.
  - When counter==SAMPLE_PERIOD-1: clear counter.
    - If pending: data_sel←pending mode, pending←0, dwell counter←0, go to SETTLE.
    - Else: go to SAMPLE.
- Mode-change requests (evaluated every cycle, in any state):
  - manual_load with manual_sel in 1..3 sets pending to manual_sel.
  - manual_load with manual_sel of 0 or 4..7 is ignored.
  - Auto: when auto_en=1 and the dwell counter reaches PKTS_PER_MODE, pending is set to next(data_sel), where next is 1→2→3→1.
  - Manual has priority over auto in the same cycle.
  - A later manual_load overwrites an earlier pending value.
- data_sel changes only on the WAIT→SETTLE transition, so it never changes while a packet is in SEND or being sampled.
- Deasserting auto_en clears an auto-generated pending request but not a manual one. This requires a 1-bit origin flag.
- Reset mid-SEND: the packet is dropped, pkt_valid=0 immediately (asynchronous), and the block restarts in SETTLE with mode 1.
- Widths: counters are 16 bits and compare with ==, so there is no saturation. Packet fields pass through unmodified with no arithmetic.

Decomposition:
- Shared package ecg_sim_pkg holds:
  - Mode constants MODE_NORMAL=3'd1, MODE_TACHY=3'd2, MODE_LOW_HRV=3'd3.
  - The 2-bit FSM state encoding.
  - A function next_mode().
  - Packet field widths (12).
- One sub-module, ecg_mode_sequencer, holds the pending/origin/dwell logic and produces apply_mode and new_sel. The top-level module keeps the FSM, counters and packet registers.

Test Plan:
Use SETTLE_CYCLES=52, SAMPLE_PERIOD=100, PKTS_PER_MODE=3.
1. Reset release, auto_en=0, pkt_ready=1 → pkt_valid first high 53 edges after release; pkt_mode=1; pkt_hr in 72..79; subsequent packets every 102 cycles; data_sel stays 1.
2. auto_en=1, pkt_ready=1 → after 3 packets data_sel goes 1→2; next packet has pkt_mode=2 and pkt_hr in 103..170; then goes to 3 and wraps back to 1; pkt_count=9 after the full cycle.
3. pkt_ready=0 for 500 cycles during SEND → pkt_valid and fields stable throughout; pkt_count unchanged; a manual_load of mode 3 during the stall keeps data_sel unchanged until after the handshake plus 100 cycles.
4. manual_load with manual_sel=5 → ignored. Same cycle as an auto-advance: manual_sel=3 with auto target 2 → data_sel becomes 3.
5. rst_n pulsed low while pkt_valid=1 → pkt_valid=0 without a clock; data_sel=1; pkt_count=0; restart timing as in test 1.
6. pkt_count preset path: run 65536 handshakes with SAMPLE_PERIOD=1 → pkt_count wraps to 0.
